// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD digits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Front-panel pulses in, display/status out, between the debouncer and the display driver.
interface stopwatch_ctrl_if #(parameter int NUM_DIGITS = 4);

  logic                    start_stop;
  logic                    clear;
  logic                    lap;
  logic [4*NUM_DIGITS-1:0] disp;
  logic                    running;
  logic                    lap_active;
  logic                    tick;
  logic                    ovf;

  modport master (
    output start_stop, clear, lap,
    input  disp, running, lap_active, tick, ovf
  );

  modport slave (
    input  start_stop, clear, lap,
    output disp, running, lap_active, tick, ovf
  );

endinterface

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One decade counter digit; is_nine feeds the carry/enable chain of the next digit.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic             is_nine
);

  logic [BCD_W-1:0] q_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= (q_q == BCD_MAX) ? '0 : q_q + 1'b1;
    end
  end

  assign q       = q_q;
  assign is_nine = (q_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap controller: FSM, count-tick prescaler, digit enable chain, lap freeze and overflow.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1000
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_ctrl_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_e                  state_q;
  logic [PW-1:0]           presc_q;
  logic                    running_q;
  logic                    lap_active_q;
  logic                    ovf_q;
  logic [4*NUM_DIGITS-1:0] frozen_q;
  logic [4*NUM_DIGITS-1:0] live;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   is_nine;
  logic                    tick;
  logic                    clr_all;
  logic                    all_nine;

  assign tick     = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign clr_all  = bus.clear && (state_q != RUN);
  assign all_nine = &is_nine;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign digit_en[k] = tick;
    end else begin : g_upper
      assign digit_en[k] = digit_en[k-1] & is_nine[k-1];
    end

    bcd_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .en      (digit_en[k]),
      .clr     (clr_all),
      .q       (live[k*BCD_W +: BCD_W]),
      .is_nine (is_nine[k])
    );
  end

  // Clear outranks start_stop, which outranks lap; the prescaler still advances on a pausing edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      ovf_q        <= 1'b0;
      frozen_q     <= '0;
    end else if (clr_all) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      ovf_q        <= 1'b0;
      frozen_q     <= '0;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (bus.start_stop) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
          if (tick && all_nine) begin
            ovf_q <= 1'b1;
          end
          if (bus.start_stop) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end else if (bus.lap) begin
            lap_active_q <= ~lap_active_q;
            if (!lap_active_q) begin
              frozen_q <= live;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.disp       = lap_active_q ? frozen_q : live;
  assign bus.running    = running_q;
  assign bus.lap_active = lap_active_q;
  assign bus.tick       = tick;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, NUM_DIGITS=4: vector table plus hand sequences.
module tb_stopwatch_ctrl;

  localparam int ND = 4;
  localparam int TD = 4;

  typedef struct {
    logic        ss;
    logic        cl;
    logic        lp;
    logic [15:0] disp;
    logic        run;
    logic        lapA;
    logic        tick;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  vec_t vecs[16];

  stopwatch_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  stopwatch_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ss, input logic cl, input logic lp);
    bus.start_stop = ss;
    bus.clear      = cl;
    bus.lap        = lp;
    @(posedge clk);
    #1;
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.lap        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] d, input logic r,
                             input logic la, input logic t, input logic o);
    vectors++;
    if (bus.disp !== d || bus.running !== r || bus.lap_active !== la ||
        bus.tick !== t || bus.ovf !== o) begin
      miscompares++;
      $display("[TB] FAIL %s: got disp=%h run=%b lap=%b tick=%b ovf=%b, expected disp=%h run=%b lap=%b tick=%b ovf=%b",
               name, bus.disp, bus.running, bus.lap_active, bus.tick, bus.ovf, d, r, la, t, o);
    end
  endtask

  initial begin
    // First 16 cycles after start: a tick every 4th cycle, count advances on the edge after it
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{ss: (i == 0), cl: 1'b0, lp: 1'b0, disp: 16'(i / 4), run: 1'b1,
                  lapA: 1'b0, tick: ((i % 4) == 3), ovf: 1'b0};
    end

    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.lap        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].ss, vecs[i].cl, vecs[i].lp);
      checkOutput($sformatf("vec%0d", i), vecs[i].disp, vecs[i].run, vecs[i].lapA,
                  vecs[i].tick, vecs[i].ovf);
    end

    // Carry from digit 0 into digit 1, then stop and clear
    idle(24);
    checkOutput("at_nine", 16'h0009, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    checkOutput("carry_10", 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("stop", 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("clear_pause", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pause with prescaler part-way through, resume keeps the partial tick
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(2);
    checkOutput("pre_pause", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("paused", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(20);
    checkOutput("paused_hold", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume_tick", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    checkOutput("resume_count", 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);

    // Lap freeze, release, and capture on a tick edge
    idle(4 * 41);
    checkOutput("pre_lap", 16'h0042, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lap_on", 16'h0042, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(31);
    checkOutput("lap_frozen", 16'h0042, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lap_off", 16'h0050, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    checkOutput("pre_lap_tick", 16'h0050, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lap_on_tick", 16'h0050, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lap_off_live", 16'h0051, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("clear2", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Run all the way to 9999 and wrap
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(4 * 9999);
    checkOutput("at_9999", 16'h9999, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    checkOutput("wrap_tick", 16'h9999, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1);
    checkOutput("wrapped", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(4);
    checkOutput("ovf_sticky", 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("clear_in_run", 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pause_ovf", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lap_in_pause", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("clear_ss_pause", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lap_in_idle", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a run
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(8);
    checkOutput("pre_reset", 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    checkOutput("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    checkOutput("post_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/pause/lap controller that sequences a cascade of decade counter digits into a multi-digit BCD stopwatch. It holds the run-state FSM, generates a prescaled count tick, and derives each digit's enable from the carries of lower digits. It also provides a lap-freeze display register and a sticky overflow flag. It sits between the debounced front-panel pulse inputs and the seven-segment display driver.

## Interface
- NUM_DIGITS, default 4: number of cascaded BCD digits (≥1).
- TICK_DIV, default 1000: clk cycles per count tick (≥2).
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_stop  in  1  one-cycle pulse that toggles run/pause.
- clear  in  1  one-cycle pulse that zeroes counts, lap and overflow when not running.
- lap  in  1  one-cycle pulse that toggles display freeze while running.
- disp  out  4*NUM_DIGITS  displayed BCD value; digit 0 is in [3:0] and is least significant.
- running  out  1  high in RUN.
- lap_active  out  1  display frozen.
- tick  out  1  one-cycle pulse, count advance strobe.
- ovf  out  1  sticky; all digits wrapped 9…9 → 0…0.

## Operation
- FSM states: IDLE, RUN, PAUSE. Reset state is IDLE.
- Transitions:
  - IDLE + start_stop → RUN.
  - RUN + start_stop → PAUSE.
  - PAUSE + start_stop → RUN.
  - IDLE/PAUSE + clear → IDLE.
  - clear in RUN is ignored.
- Same-cycle priority: clear > start_stop > lap. In PAUSE, clear+start_stop → IDLE only.
- Entering IDLE zeroes all digits, the prescaler, lap_active, the frozen register and ovf.
- Prescaler counts 0..TICK_DIV-1 only in RUN and wraps to 0. It holds its value in PAUSE, so a resumed run does not restart the partial tick.
- tick = (state==RUN) & (prescaler==TICK_DIV-1). It is combinational from registers and is never high outside RUN.
- Digit enables:
  - digit 0 en = tick.
  - digit k en = tick & (digits 0..k-1 all ==9).
- Each digit counts 0..9 and wraps to 0. Digits hold when not enabled.
- Overflow: a tick while all digits ==9 wraps every digit to 0 and sets ovf. ovf stays high until IDLE is entered or reset.
- Lap behaviour:
  - A lap pulse in RUN with lap_active=0 captures the live digits into the frozen register and sets lap_active. The captured value is the pre-edge value, even if a tick occurs on the same edge.
  - A lap pulse in RUN with lap_active=1 clears lap_active.
  - lap is ignored in IDLE and PAUSE. lap_active survives RUN↔PAUSE.
- disp = lap_active ? frozen : live digits.
- Digit values are always legal BCD (0–9). Values 10–15 are unreachable.

## Timing
- Reset values:
  - disp=0, running=0, lap_active=0, tick=0, ovf=0.
  - FSM=IDLE, prescaler=0.
- start_stop sampled at edge N: running changes after edge N.
- First tick: the cycle in which the prescaler reaches TICK_DIV-1, i.e. TICK_DIV cycles after RUN is entered from IDLE.
- Digits update on the edge that samples tick=1. The new value is visible the following cycle.
- Tick spacing in steady RUN is exactly TICK_DIV cycles.
- A start_stop pulse coinciding with tick in RUN: the tick still counts on that edge, then the FSM goes to PAUSE.
- Reset mid-operation forces all outputs and state to reset values immediately (asynchronous).

## Structure
- Shared package `stopwatch_pkg` contains:
  - the state enum (IDLE/RUN/PAUSE),
  - the BCD digit width constant (4),
  - the BCD max constant (9).
- One natural sub-module: `bcd_digit`.
  - Inputs: clk, rst, en, clr.
  - Outputs: q[3:0], is_nine (combinational carry condition).
  - Instantiate NUM_DIGITS times via generate. The controller builds the enable chain from the is_nine outputs.
- Prescaler, FSM, lap register and ovf flag live in stopwatch_ctrl.

## Test plan
- TICK_DIV=4, NUM_DIGITS=4, start_stop at cycle 0 → tick at cycles 4, 8, 12; disp=0x0003 at cycle 13; running=1.
- Run to 0x0009, then one more tick → disp=0x0010; then stop, clear → disp=0x0000, IDLE, running=0.
- Pause mid-tick (prescaler=2) for 20 cycles, then resume → next tick 1 cycle after resume; disp unchanged while paused.
- Lap at disp=0x0042 → disp stays 0x0042 while live digits advance to 0x0050. Second lap → disp=0x0050. A lap coinciding with a tick captures the pre-tick value.
- Preload to 0x9999 by running, tick → disp=0x0000, ovf=1. ovf holds through further ticks and clears only on clear in PAUSE.
- clear pulse in RUN → ignored. clear+start_stop in PAUSE → IDLE. rst low mid-RUN → all outputs 0 asynchronously.
